// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem request/response, redirect, flush, instret.
// Outputs come straight from flops or the state register, so no input reaches an output combinationally.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        misaligned,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        discard_q, discard_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] retire_tgt;

  assign retire_tgt = redirect ? redirect_pc : instr_pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    discard_d    = discard_q;
    misaligned_d = misaligned_q;
    instret_d    = instret_q;

    case (state_q)
      S_FETCH: begin
        if (flush) begin
          fetch_pc_d = flush_pc;
          if (flush_pc[1:0] != 2'b00) begin
            state_d      = S_HALT;
            misaligned_d = 1'b1;
          end else if (imem_req_ready) begin
            // The request already went out for the old PC; its response must be dropped.
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (flush) begin
          fetch_pc_d = flush_pc;
          if (flush_pc[1:0] != 2'b00) begin
            state_d      = S_HALT;
            misaligned_d = 1'b1;
          end else if (imem_rsp_valid) begin
            state_d   = S_FETCH;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            instr_d    = imem_rsp_data;
            instr_pc_d = fetch_pc_q;
            state_d    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (flush) begin
          fetch_pc_d = flush_pc;
          if (flush_pc[1:0] != 2'b00) begin
            state_d      = S_HALT;
            misaligned_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else if (instr_ready) begin
          instret_d  = instret_q + 32'd1;
          fetch_pc_d = retire_tgt;
          if (retire_tgt[1:0] != 2'b00) begin
            state_d      = S_HALT;
            misaligned_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      instr_q      <= 32'd0;
      instr_pc_q   <= 32'd0;
      discard_q    <= 1'b0;
      misaligned_q <= 1'b0;
      instret_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      discard_q    <= discard_d;
      misaligned_q <= misaligned_d;
      instret_q    <= instret_d;
    end
  end

  assign imem_req_valid = (state_q == S_FETCH);
  assign instr_valid    = (state_q == S_HOLD);
  assign imem_addr      = fetch_pc_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign misaligned     = misaligned_q;
  assign instret        = instret_q;

endmodule
